// File: rtl/mstreset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mstreset_seq
//  Description : Master reset sequencer. Synchronises the pin-level nreset,
//                holds every domain in reset for HOLD_CYCLES, then releases
//                NUM_CHAN domains in index order, STAGGER_CYCLES apart. A
//                software request re-runs the hold/release sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module mstreset_seq #(
    parameter int NUM_CHAN       = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                sw_rst_req,
    output logic [NUM_CHAN-1:0] chan_nreset,
    output logic                rst_done,
    output logic [7:0]          sw_rst_cnt
);

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [7:0]          C_HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]          C_STAG_LAST = 8'(STAGGER_CYCLES - 1);
    localparam logic [NUM_CHAN-1:0] C_ALL       = '1;
    localparam logic [NUM_CHAN-1:0] C_FIRST     = C_ALL >> (NUM_CHAN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_d;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_d;
    logic [NUM_CHAN-1:0]    r_chan;
    logic [NUM_CHAN-1:0]    w_chan_d;
    logic                   r_done;
    logic                   w_done_d;
    logic [7:0]             r_swcnt;
    logic [7:0]             w_swcnt_d;

    logic                   w_sync_ok;
    logic                   w_sync_lead;
    logic                   w_sw_acc;
    logic [NUM_CHAN-1:0]    w_chan_step;
    logic [NUM_CHAN-1:0]    w_hold_rel;

    // The stage feeding sync_ok leads it by one edge; leaving SYNC on that
    // value makes the FSM enter HOLD on the very edge sync_ok rises.
    assign w_sync_ok   = r_sync[SYNC_STAGES-1];
    assign w_sync_lead = r_sync[SYNC_STAGES-2];

    // A request counts only once the reset is synchronised and the FSM is live.
    assign w_sw_acc    = sw_rst_req && w_sync_ok && (r_state != ST_SYNC);

    // Released bits are always a contiguous low-order run, so the next
    // release is a shift-in of one more 1.
    assign w_chan_step = (r_chan << 1) | C_FIRST;
    assign w_hold_rel  = (STAGGER_CYCLES == 0) ? C_ALL : C_FIRST;

    // Deassertion synchroniser: shifts in 1, cleared immediately by nreset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // State, counters and registered outputs, all cleared by nreset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_SYNC;
            r_cnt   <= 8'd0;
            r_chan  <= '0;
            r_done  <= 1'b0;
            r_swcnt <= 8'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_chan  <= w_chan_d;
            r_done  <= w_done_d;
            r_swcnt <= w_swcnt_d;
        end
    end

    // Next-state logic: hold count, staggered release, software restart.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_chan_d  = r_chan;
        w_done_d  = r_done;
        w_swcnt_d = r_swcnt;

        case (r_state)
            ST_SYNC: begin
                if (w_sync_lead) begin
                    w_state_d = ST_HOLD;
                    w_cnt_d   = 8'd0;
                end
            end
            ST_HOLD: begin
                if (r_cnt == C_HOLD_LAST) begin
                    w_chan_d = w_hold_rel;
                    w_cnt_d  = 8'd0;
                    if (&w_hold_rel) begin
                        w_done_d  = 1'b1;
                        w_state_d = ST_RUN;
                    end else begin
                        w_state_d = ST_RELEASE;
                    end
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            ST_RELEASE: begin
                if (r_cnt == C_STAG_LAST) begin
                    w_chan_d = w_chan_step;
                    w_cnt_d  = 8'd0;
                    if (&w_chan_step) begin
                        w_done_d  = 1'b1;
                        w_state_d = ST_RUN;
                    end
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            ST_RUN: begin
                w_state_d = ST_RUN;
            end
            default: begin
                w_state_d = ST_SYNC;
            end
        endcase

        // A software request overrides any progress and restarts the hold.
        if (w_sw_acc) begin
            w_state_d = ST_HOLD;
            w_cnt_d   = 8'd0;
            w_chan_d  = '0;
            w_done_d  = 1'b0;
            w_swcnt_d = (r_swcnt != 8'hFF) ? (r_swcnt + 8'd1) : r_swcnt;
        end
    end

    assign chan_nreset = r_chan;
    assign rst_done    = r_done;
    assign sw_rst_cnt  = r_swcnt;

endmodule
`default_nettype wire

// File: tb/tb_mstreset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mstreset_seq
//  Description : Self-checking bench for mstreset_seq: default instance plus
//                two parameter-corner instances sharing clk and nreset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mstreset_seq;

    logic       clk    = 1'b0;
    logic       nreset = 1'b1;
    logic       sw     = 1'b0;
    logic       sw_off = 1'b0;

    logic [3:0] chan;
    logic       done;
    logic [7:0] cnt;

    logic [0:0] chan_a;
    logic       done_a;
    logic [7:0] cnt_a;

    logic [3:0] chan_b;
    logic       done_b;
    logic [7:0] cnt_b;

    mstreset_seq u_dut (
        .clk         (clk),
        .nreset      (nreset),
        .sw_rst_req  (sw),
        .chan_nreset (chan),
        .rst_done    (done),
        .sw_rst_cnt  (cnt)
    );

    mstreset_seq #(
        .NUM_CHAN       (1),
        .HOLD_CYCLES    (1),
        .STAGGER_CYCLES (0),
        .SYNC_STAGES    (2)
    ) u_dut_a (
        .clk         (clk),
        .nreset      (nreset),
        .sw_rst_req  (sw_off),
        .chan_nreset (chan_a),
        .rst_done    (done_a),
        .sw_rst_cnt  (cnt_a)
    );

    mstreset_seq #(
        .NUM_CHAN       (4),
        .HOLD_CYCLES    (16),
        .STAGGER_CYCLES (0),
        .SYNC_STAGES    (2)
    ) u_dut_b (
        .clk         (clk),
        .nreset      (nreset),
        .sw_rst_req  (sw_off),
        .chan_nreset (chan_b),
        .rst_done    (done_b),
        .sw_rst_cnt  (cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] chan;
        logic       done;
        logic [7:0] cnt;
        logic       ca;
        logic       cb;
    } exp_t;

    exp_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;   // index of last rising edge since nreset release (E1 = 1)
    int t0    = 2;   // reference edge of current sequence: release k at t0+16+4k
    int swc   = 0;   // expected accepted software request count

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h (edge %0d, t=%0t)", tag, act, exp, cyc, $time);
        end
    endtask

    function automatic logic [3:0] model_chan(input int start, input int c);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) begin
            m[k] = (c >= start + 16 + 4 * k);
        end
        return m;
    endfunction

    // Drive one cycle of stimulus, push the expected outputs after the
    // coming edge, then pop and compare once the edge has happened.
    task automatic drive(input logic s);
        exp_t e;
        exp_t g;
        int   c;
        c = cyc + 1;
        // HOLD is entered after E2, so requests count from E3 on.
        if (s && c >= 3) begin
            t0 = c;
            if (swc < 255) swc++;
        end
        e.cyc  = c;
        e.chan = model_chan(t0, c);
        e.done = e.chan[3];
        e.cnt  = 8'(swc);
        e.ca   = (c >= 3);
        e.cb   = (c >= 18);
        exp_q.push_back(e);
        sw = s;
        @(posedge clk);
        #1;
        cyc = c;
        g = exp_q.pop_front();
        check("chan_nreset", 32'(chan), 32'(g.chan));
        check("rst_done",    32'(done), 32'(g.done));
        check("sw_rst_cnt",  32'(cnt),  32'(g.cnt));
        check("cornerA",     {22'd0, cnt_a, done_a, chan_a}, {22'd0, 8'd0, g.ca, g.ca});
        check("cornerB",     {19'd0, cnt_b, done_b, chan_b}, {19'd0, 8'd0, g.cb, {4{g.cb}}});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dflt"}, {19'd0, cnt, done, chan},       32'd0);
        check({tag, "_a"},    {22'd0, cnt_a, done_a, chan_a}, 32'd0);
        check({tag, "_b"},    {19'd0, cnt_b, done_b, chan_b}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        nreset = 1'b1;
        cyc = 0;
        t0  = 2;
        swc = 0;
    endtask

    initial begin
        // Power-on: request held high through reset and SYNC must be ignored.
        #1;
        nreset = 1'b0;
        sw     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        release_reset();
        drive(1'b1);
        drive(1'b1);
        repeat (32) drive(1'b0);           // through E34, 1111 from E30

        // Software reset in RUN at S=35: 0001 after E51, 1111 after E63.
        drive(1'b1);
        repeat (33) drive(1'b0);

        // Asynchronous reset between edges while in RUN.
        #3;
        nreset = 1'b0;
        #1;
        check_all_zero("async");
        repeat (2) @(posedge clk);
        release_reset();

        // Software reset during RELEASE at E24: 0001 after E40, 1111 after E52.
        repeat (23) drive(1'b0);
        drive(1'b1);
        repeat (34) drive(1'b0);

        // Request held high for 300 edges: each counts, saturating at 255.
        repeat (300) drive(1'b1);
        repeat (32) drive(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
